// File: rtl/fct_credit_ctrl.sv
//-----------------------------------------------------------------------------
// Module   : fct_credit_ctrl
// Function : SpaceWire receive-side FCT scheduler and credit tracker.
// Revision : 1.0 - initial release
//-----------------------------------------------------------------------------
`default_nettype none

module fct_credit_ctrl #(
  parameter int MAX_CREDIT  = 56,
  parameter int CREDIT_STEP = 8,
  parameter int CWIDTH      = 6,
  parameter int PWIDTH      = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              link_run,
  input  logic              slot_free,
  input  logic              rx_nchar,
  input  logic              fct_ack,
  output logic              fct_req,
  output logic [CWIDTH-1:0] credit,
  output logic [PWIDTH-1:0] pending_fct,
  output logic              credit_error,
  output logic              busy
);

  localparam logic [PWIDTH-1:0] c_max_fct    = PWIDTH'(MAX_CREDIT / CREDIT_STEP);
  localparam logic [CWIDTH-1:0] c_max_credit = CWIDTH'(MAX_CREDIT);
  localparam logic [CWIDTH-1:0] c_req_limit  = CWIDTH'(MAX_CREDIT - CREDIT_STEP);
  localparam logic [CWIDTH:0]   c_step_ext   = (CWIDTH+1)'(CREDIT_STEP);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t              r_state;
  logic                r_link_prev;
  logic                r_fct_req;
  logic [CWIDTH-1:0]   r_credit;
  logic [PWIDTH-1:0]   r_pending;
  logic                r_credit_error;
  logic                r_busy;

  logic                w_xfer;
  logic                w_rise;
  logic [CWIDTH:0]     w_credit_sum;
  logic [CWIDTH:0]     w_credit_after;
  logic                w_set_err;
  logic [CWIDTH-1:0]   w_credit_next;
  logic [PWIDTH-1:0]   w_pending_next;

  assign w_xfer = r_fct_req & fct_ack;
  assign w_rise = link_run & ~r_link_prev;

  // Credit: grant on transfer, consume on N-char; an N-char with nothing granted is an error.
  always_comb begin
    w_set_err      = 1'b0;
    w_credit_sum   = {1'b0, r_credit} + (w_xfer ? c_step_ext : '0);
    w_credit_after = w_credit_sum;
    if (rx_nchar) begin
      if (w_credit_sum != '0) begin
        w_credit_after = w_credit_sum - 1'b1;
      end else begin
        w_set_err = 1'b1;
      end
    end
    if (w_credit_after > {1'b0, c_max_credit}) begin
      w_credit_next = c_max_credit;
    end else begin
      w_credit_next = w_credit_after[CWIDTH-1:0];
    end
  end

  always_comb begin
    w_pending_next = r_pending;
    if (w_rise) begin
      w_pending_next = c_max_fct;
    end else if (slot_free && !w_xfer) begin
      if (r_pending != c_max_fct) begin
        w_pending_next = r_pending + 1'b1;
      end
    end else if (w_xfer && !slot_free) begin
      if (r_pending != '0) begin
        w_pending_next = r_pending - 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset || !link_run) begin
      r_state        <= S_IDLE;
      r_link_prev    <= 1'b0;
      r_fct_req      <= 1'b0;
      r_credit       <= '0;
      r_pending      <= '0;
      r_credit_error <= 1'b0;
      r_busy         <= 1'b0;
    end else begin
      r_link_prev <= 1'b1;
      r_credit    <= w_credit_next;
      r_pending   <= w_pending_next;
      if (w_set_err) begin
        r_credit_error <= 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          // Guard evaluated only here keeps credit within MAX_CREDIT.
          if (r_pending != '0 && r_credit <= c_req_limit) begin
            r_state   <= S_REQ;
            r_fct_req <= 1'b1;
            r_busy    <= 1'b1;
          end
        end
        S_REQ: begin
          if (w_xfer) begin
            r_state   <= S_GAP;
            r_fct_req <= 1'b0;
            r_busy    <= 1'b1;
          end
        end
        S_GAP: begin
          r_state   <= S_IDLE;
          r_fct_req <= 1'b0;
          r_busy    <= 1'b0;
        end
        default: begin
          r_state   <= S_IDLE;
          r_fct_req <= 1'b0;
          r_busy    <= 1'b0;
        end
      endcase
    end
  end

  assign fct_req      = r_fct_req;
  assign credit       = r_credit;
  assign pending_fct  = r_pending;
  assign credit_error = r_credit_error;
  assign busy         = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_fct_credit_ctrl.sv
//-----------------------------------------------------------------------------
// Module   : tb_fct_credit_ctrl
// Function : Directed and random checks of fct_credit_ctrl against a reference model.
// Revision : 1.0 - initial release
//-----------------------------------------------------------------------------
`default_nettype none

module tb_fct_credit_ctrl;

  logic       clock;
  logic       reset;
  logic       link_run;
  logic       slot_free;
  logic       rx_nchar;
  logic       fct_ack;
  logic       fct_req;
  logic [5:0] credit;
  logic [2:0] pending_fct;
  logic       credit_error;
  logic       busy;

  int errors = 0;
  int checks = 0;

  // Reference model: token counts plus "request outstanding" and post-transfer cooldown.
  int m_credit, m_pending, m_err, m_req, m_cool, m_prev;

  fct_credit_ctrl dut (
    .clock       (clock),
    .reset       (reset),
    .link_run    (link_run),
    .slot_free   (slot_free),
    .rx_nchar    (rx_nchar),
    .fct_ack     (fct_ack),
    .fct_req     (fct_req),
    .credit      (credit),
    .pending_fct (pending_fct),
    .credit_error(credit_error),
    .busy        (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input bit rs, input bit l, input bit s, input bit r, input bit a);
    int xfer, old_p, old_c, c;
    if (rs || !l) begin
      m_credit = 0; m_pending = 0; m_err = 0; m_req = 0; m_cool = 0; m_prev = 0;
    end else begin
      xfer  = (m_req == 1 && a) ? 1 : 0;
      old_p = m_pending;
      old_c = m_credit;
      if (m_prev == 0) m_pending = 7;
      else begin
        m_pending = old_p + (s ? 1 : 0) - xfer;
        if (m_pending > 7) m_pending = 7;
        if (m_pending < 0) m_pending = 0;
      end
      c = old_c + 8 * xfer;
      if (r) begin
        if (c > 0) c = c - 1;
        else m_err = 1;
      end
      m_credit = (c > 56) ? 56 : c;
      if (m_req == 1) begin
        if (xfer == 1) begin m_req = 0; m_cool = 1; end
      end else if (m_cool > 0) m_cool = m_cool - 1;
      else if (old_p != 0 && old_c <= 48) m_req = 1;
      m_prev = 1;
    end
  endtask

  task automatic step(input bit rs, input bit l, input bit s, input bit r, input bit a);
    reset = rs; link_run = l; slot_free = s; rx_nchar = r; fct_ack = a;
    @(posedge clock);
    model_edge(rs, l, s, r, a);
    #1;
    chk("fct_req", fct_req, m_req);
    chk("credit", credit, m_credit);
    chk("pending_fct", pending_fct, m_pending);
    chk("credit_error", credit_error, m_err);
    chk("busy", busy, (m_req == 1 || m_cool > 0) ? 1 : 0);
  endtask

  initial begin
    bit l;
    m_credit = 0; m_pending = 0; m_err = 0; m_req = 0; m_cool = 0; m_prev = 0;
    reset = 1'b1; link_run = 1'b0; slot_free = 1'b0; rx_nchar = 1'b0; fct_ack = 1'b0;

    step(1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 1);
    chk("reset_fct_req", fct_req, 0);
    chk("reset_credit", credit, 0);
    chk("reset_busy", busy, 0);

    // Full advertisement after link start with ack tied high.
    for (int i = 0; i < 24; i++) step(0, 1, 0, 0, 1);
    chk("start_credit", credit, 56);
    chk("start_pending", pending_fct, 0);
    chk("start_err", credit_error, 0);

    for (int i = 0; i < 8; i++) step(0, 1, 0, 1, 0);
    chk("rx8_credit", credit, 48);
    step(0, 1, 1, 0, 0);
    chk("slot_pending", pending_fct, 1);
    chk("slot_req_early", fct_req, 0);
    step(0, 1, 0, 0, 0);
    chk("slot_req_rise", fct_req, 1);
    step(0, 1, 0, 0, 1);
    chk("ack_credit", credit, 56);
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);

    for (int i = 0; i < 8; i++) step(0, 1, 0, 1, 0);
    step(0, 1, 1, 0, 0);
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 1, 1);
    chk("xfer_rx_credit", credit, 55);
    step(0, 1, 0, 1, 0);
    chk("rx_after_credit", credit, 54);

    // Credit error with zero credit, cleared by link drop.
    step(0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 1, 0);
    chk("zero_err", credit_error, 1);
    chk("zero_credit", credit, 0);
    step(0, 0, 0, 0, 0);
    chk("drop_err", credit_error, 0);
    chk("drop_pending", pending_fct, 0);

    // Pending saturation with ack held low, then slot_free coincident with transfer.
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    step(0, 1, 1, 0, 0);
    chk("sat_pending", pending_fct, 7);
    chk("sat_req", fct_req, 1);
    step(0, 1, 1, 0, 1);
    chk("sat_xfer_pending", pending_fct, 7);
    chk("sat_xfer_credit", credit, 8);

    // Reset during an active handshake.
    step(0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    chk("pre_rst_req", fct_req, 1);
    step(1, 1, 0, 0, 1);
    chk("rst_req", fct_req, 0);
    chk("rst_credit", credit, 0);
    chk("rst_busy", busy, 0);

    l = 1'b1;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 39) == 0) l = ~l;
      step($urandom_range(0, 149) == 0, l,
           $urandom_range(0, 4) == 0, $urandom_range(0, 2) == 0,
           $urandom_range(0, 1) == 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
